// File: rtl/plic_lite_if.sv
// Register bus for plic_lite: word select, write data/strobe, combinational read data.
interface plic_lite_if;
   logic [2:0]  a;
   logic [31:0] d;
   logic        we;
   logic [31:0] spo;

   modport master (output a, d, we, input spo);
   modport slave  (input a, d, we, output spo);
endinterface

// File: rtl/plic_lite.sv
// plic_lite: small platform interrupt controller with one claim/complete context.
// Sources are synchronised, latched into PENDING (level or rising edge), masked by
// ENABLE, and the lowest enabled pending index is handed out on m_eip_reply.
module plic_lite #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst,
   plic_lite_if.slave       bus,
   input  logic [N_SRC-1:0] src,
   output logic             m_eip,
   input  logic             m_eip_reply
);

   logic [N_SRC-1:0] r_s1, r_s2, r_s2_d;
   logic [N_SRC-1:0] r_pending, r_enable, r_edge;
   logic [4:0]       r_claim;
   logic             r_in_service;
   logic             r_m_eip;

   logic [N_SRC-1:0] w_set, w_masked, w_win_oh, w_clr;
   logic [4:0]       w_winner;
   logic             w_found, w_reply_ok, w_claim_hit;
   logic             w_wr_enable, w_wr_edge, w_complete;
   logic             w_unused;

   assign w_masked    = r_pending & r_enable;
   assign w_reply_ok  = m_eip_reply & ~r_in_service;
   assign w_claim_hit = w_reply_ok & w_found;
   assign w_clr       = w_claim_hit ? w_win_oh : '0;
   assign w_wr_enable = bus.we && (bus.a == 3'd1);
   assign w_wr_edge   = bus.we && (bus.a == 3'd2);
   assign w_complete  = bus.we && (bus.a == 3'd4);
   assign m_eip       = r_m_eip;
   assign w_unused    = &{1'b0, bus.d};

   // Pending set: level mode on synchronised high, edge mode on its rising edge.
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         w_set[i] = r_edge[i] ? (r_s2[i] & ~r_s2_d[i]) : r_s2[i];
      end
   end

   // Priority select: scan downwards so the lowest enabled pending index wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_win_oh = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_masked[i]) begin
            w_found     = 1'b1;
            w_winner    = 5'(i + 1);
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
         end
      end
   end

   // Synchronisers, configuration, pending, claim/service state and m_eip.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1         <= '0;
         r_s2         <= '0;
         r_s2_d       <= '0;
         r_pending    <= '0;
         r_enable     <= '0;
         r_edge       <= '0;
         r_claim      <= '0;
         r_in_service <= 1'b0;
         r_m_eip      <= 1'b0;
      end else begin
         r_s1      <= src;
         r_s2      <= r_s1;
         r_s2_d    <= r_s2;
         // set beats a simultaneous claim-clear on the same bit
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_wr_enable) r_enable <= bus.d[N_SRC-1:0];
         if (w_wr_edge)   r_edge   <= bus.d[N_SRC-1:0];
         if (w_reply_ok)  r_claim  <= w_found ? w_winner : 5'd0;
         // a claim can only happen when not in service, so it never races a completion
         if (w_claim_hit)     r_in_service <= 1'b1;
         else if (w_complete) r_in_service <= 1'b0;
         r_m_eip <= (|w_masked) & ~r_in_service;
      end
   end

   // Combinational register read; unmapped words and COMPLETE read as zero.
   always_comb begin
      bus.spo = '0;
      case (bus.a)
         3'd0:    bus.spo = 32'(r_pending);
         3'd1:    bus.spo = 32'(r_enable);
         3'd2:    bus.spo = 32'(r_edge);
         3'd3:    bus.spo = 32'(r_claim);
         default: bus.spo = '0;
      endcase
   end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite with hand-computed expectations.
module tb_plic_lite;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] src = '0;
   logic       m_eip;
   logic       m_eip_reply = 1'b0;
   int         errors = 0;
   int         checks = 0;

   plic_lite_if bus ();

   plic_lite #(.N_SRC(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .src         (src),
      .m_eip       (m_eip),
      .m_eip_reply (m_eip_reply)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      bus.a = addr;
      #1;
      chk(tag, bus.spo, exp);
   endtask

   task automatic eip_chk(input string tag, input logic exp);
      chk(tag, {31'b0, m_eip}, {31'b0, exp});
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      bus.a  = addr;
      bus.d  = data;
      bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
      bus.d  = '0;
   endtask

   task automatic reply();
      m_eip_reply = 1'b1;
      tick();
      m_eip_reply = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      bus.a  = '0;
      bus.d  = '0;
      bus.we = 1'b0;

      // reset state
      do_reset();
      rd_chk("rst_pending", 3'd0, 32'h0);
      rd_chk("rst_enable", 3'd1, 32'h0);
      rd_chk("rst_edge", 3'd2, 32'h0);
      rd_chk("rst_claim", 3'd3, 32'h0);
      eip_chk("rst_m_eip", 1'b0);

      // level latency on src[0]
      wr(3'd1, 32'h0000_0001);
      rd_chk("enable_rb", 3'd1, 32'h1);
      wr(3'd5, 32'hFFFF_FFFF);
      rd_chk("unmapped_rd", 3'd5, 32'h0);
      src = 8'h01;
      tick(2);
      rd_chk("lat_pend_e2", 3'd0, 32'h0);
      tick();
      rd_chk("lat_pend_e3", 3'd0, 32'h1);
      eip_chk("lat_eip_e3", 1'b0);
      tick();
      eip_chk("lat_eip_e4", 1'b1);
      reply();
      rd_chk("lvl_claim", 3'd3, 32'd1);
      rd_chk("lvl_set_wins", 3'd0, 32'h1);
      tick();
      eip_chk("lvl_eip_insvc", 1'b0);
      src = 8'h00;

      // priority among src[2] and src[3]
      do_reset();
      wr(3'd1, 32'h0000_00FF);
      src = 8'h0C;
      tick(3);
      rd_chk("pri_pend", 3'd0, 32'h0C);
      tick();
      eip_chk("pri_eip", 1'b1);
      src = 8'h00;
      tick(3);
      reply();
      rd_chk("pri_claim3", 3'd3, 32'd3);
      rd_chk("pri_pend_clr", 3'd0, 32'h08);
      tick();
      eip_chk("pri_eip_drop", 1'b0);
      wr(3'd4, 32'h0);
      rd_chk("complete_rd0", 3'd4, 32'h0);
      tick();
      eip_chk("pri_eip_again", 1'b1);
      reply();
      rd_chk("pri_claim4", 3'd3, 32'd4);
      rd_chk("pri_pend_empty", 3'd0, 32'h0);

      // edge mode on src[1]
      do_reset();
      wr(3'd2, 32'h0000_0002);
      wr(3'd1, 32'h0000_0002);
      rd_chk("edge_rb", 3'd2, 32'h2);
      src = 8'h02;
      tick(3);
      rd_chk("edge_pend", 3'd0, 32'h2);
      tick();
      eip_chk("edge_eip", 1'b1);
      reply();
      rd_chk("edge_claim", 3'd3, 32'd2);
      rd_chk("edge_pend_clr", 3'd0, 32'h0);
      wr(3'd4, 32'h0);
      tick(3);
      eip_chk("edge_held_no_eip", 1'b0);
      rd_chk("edge_held_no_pend", 3'd0, 32'h0);
      src = 8'h00;
      tick(3);
      src = 8'h02;
      tick(3);
      rd_chk("edge_repend", 3'd0, 32'h2);
      tick();
      eip_chk("edge_reeip", 1'b1);
      src = 8'h00;

      // masking by ENABLE
      do_reset();
      src = 8'h20;
      tick(4);
      rd_chk("mask_pend", 3'd0, 32'h20);
      eip_chk("mask_eip0", 1'b0);
      wr(3'd1, 32'h0000_0020);
      eip_chk("mask_eip_wr_edge", 1'b0);
      tick();
      eip_chk("mask_eip1", 1'b1);
      wr(3'd1, 32'h0);
      tick();
      eip_chk("mask_eip_off", 1'b0);
      src = 8'h00;

      // corner events
      do_reset();
      wr(3'd1, 32'h0000_0005);
      src = 8'h05;
      tick(4);
      src = 8'h00;
      tick(3);
      rd_chk("cor_pend", 3'd0, 32'h05);
      reply();
      rd_chk("cor_claim1", 3'd3, 32'd1);
      reply();
      rd_chk("cor_insvc_claim", 3'd3, 32'd1);
      rd_chk("cor_insvc_pend", 3'd0, 32'h04);
      bus.a = 3'd4;
      bus.d = 32'h0;
      bus.we = 1'b1;
      m_eip_reply = 1'b1;
      tick();
      bus.we = 1'b0;
      m_eip_reply = 1'b0;
      rd_chk("cor_cmpl_reply_claim", 3'd3, 32'd1);
      rd_chk("cor_cmpl_reply_pend", 3'd0, 32'h04);
      tick();
      eip_chk("cor_cmpl_eip", 1'b1);
      reply();
      rd_chk("cor_claim3", 3'd3, 32'd3);
      wr(3'd4, 32'h0);
      reply();
      rd_chk("cor_empty_claim", 3'd3, 32'd0);
      src = 8'h01;
      tick(4);
      eip_chk("cor_empty_no_insvc", 1'b1);
      src = 8'h00;

      // reset mid-service
      do_reset();
      wr(3'd1, 32'h0000_0001);
      wr(3'd2, 32'h0000_0001);
      src = 8'h01;
      tick(4);
      src = 8'h00;
      reply();
      rd_chk("ms_claim_pre", 3'd3, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_chk("ms_pending", 3'd0, 32'h0);
      rd_chk("ms_enable", 3'd1, 32'h0);
      rd_chk("ms_edge", 3'd2, 32'h0);
      rd_chk("ms_claim", 3'd3, 32'h0);
      eip_chk("ms_eip", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/plic_lite.md
PLIC_LITE -- requirements
Module: plic_lite

Interface
REQ-001 Parameter N_SRC, default 8, is the number of external interrupt sources, legal range 1..31.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port a, input, 3 bits: register word select.
REQ-005 Port d, input, 32 bits: write data.
REQ-006 Port we, input, 1 bit: write strobe, one write per cycle when high.
REQ-007 Port spo, output, 32 bits: combinational read data for the register selected by a.
REQ-008 Port src, input, N_SRC bits: asynchronous interrupt request lines; src[0] has the highest priority.
REQ-009 Port m_eip, output, 1 bit: registered machine external interrupt request to the privilege unit.
REQ-010 Port m_eip_reply, input, 1 bit: one-cycle pulse from the privilege unit when it takes the external interrupt.

Function
REQ-011 Each src bit passes through a 2-flop synchroniser (s1, s2) plus a delay flop s2_d for edge detection.
REQ-012 Register map (spo; unlisted a reads 0, ignores writes):
- 0 PENDING, RO
- 1 ENABLE, RW [N_SRC-1:0]
- 2 EDGE mode, RW [N_SRC-1:0]; 1 = rising edge, 0 = level
- 3 CLAIM, RO: claimed source index+1, 0 = none
- 4 COMPLETE, WO: any write clears in_service; reads 0.
Unimplemented bits read 0.
REQ-013 Pending set, per source i: level mode when s2[i]=1; edge mode when s2[i]=1 and s2_d[i]=0.
REQ-014 Pending clear: bit i clears only when claimed; if set and clear coincide on the same bit, set wins.
REQ-015 Sources are gated into PENDING regardless of ENABLE; ENABLE gates only m_eip and claim selection.
REQ-016 State in_service, 1 bit: set on a successful claim, cleared by a COMPLETE write.
REQ-017 m_eip next-state = (|(PENDING & ENABLE)) & ~in_service; registered, so one cycle after its condition.
REQ-018 Claim happens on a cycle where m_eip_reply=1 and in_service=0:
- winner = lowest index i with PENDING[i]&ENABLE[i]
- CLAIM <= i+1, clear PENDING[i], set in_service.
REQ-019 If m_eip_reply=1 with no enabled pending source, CLAIM <= 0 and in_service stays 0.
REQ-020 m_eip_reply while in_service=1 is ignored; CLAIM and PENDING are unchanged.
REQ-021 COMPLETE write and m_eip_reply in the same cycle: in_service clears, the reply is ignored (REQ-020 evaluates the pre-edge in_service).
REQ-022 CLAIM holds its value until the next successful or empty claim; reads have no side effects.
REQ-023 Latency: src rising, first sampled at edge 1 → s2 at edge 2 → PENDING at edge 3 → m_eip at edge 4.
REQ-024 Writes to ENABLE or EDGE take effect from the following cycle; clearing ENABLE[i] drops m_eip next cycle if no other enabled source is pending.

Reset
REQ-025 On rst the following clear to 0: s1, s2, s2_d, PENDING, ENABLE, EDGE, CLAIM, in_service and m_eip.
REQ-026 rst wins over every simultaneous event, including mid-claim and mid-service; spo reflects the reset values the next cycle.

Verification
REQ-027 Level latency: ENABLE=0x01, EDGE=0, src[0] raised → PENDING[0]=1 three edges later, m_eip=1 four edges later.
REQ-028 Priority: ENABLE=0xFF, src=0x0C → reply pulse → CLAIM=3, PENDING bit2 cleared, m_eip=0 next cycle; after COMPLETE, m_eip=1 and the next claim gives CLAIM=4.
REQ-029 Edge mode: EDGE=0x02, ENABLE=0x02, src[1] held high → exactly one pending; after claim and complete, m_eip stays 0 until src[1] falls and rises again.
REQ-030 Mask:
- src[5] high, ENABLE=0 → PENDING[5]=1, m_eip=0
- write ENABLE=0x20 → m_eip=1 after one cycle.
REQ-031 Corner events:
- reply with nothing pending → CLAIM=0, in_service=0
- reply during in_service → CLAIM unchanged
- COMPLETE and reply in the same cycle → in_service=0 and no claim.
REQ-032 Reset mid-service: claimed source, rst for one cycle → all registers 0, m_eip=0, CLAIM=0.
